// File: rtl/uart_rx_pkg.sv
// Shared definitions for the parametrised UART receiver: parity encoding,
// register map, FSM state enum and error bit positions.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BREAK_WAIT
  } rx_state_e;

  localparam logic [3:0] ADDR_FRAME  = 4'b0100;
  localparam logic [3:0] ADDR_DIV_LO = 4'b0101;
  localparam logic [3:0] ADDR_DIV_HI = 4'b0110;

  localparam int ERR_PARITY  = 0;
  localparam int ERR_FRAMING = 1;
  localparam int ERR_OVERRUN = 2;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Configuration write bus and received-word/error output bundle of uart_rx_param.
// Handshakes: a config write happens on a cycle with c_valid & c_ready; a word
// moves on a cycle with valid_out & out_ready, and out is held while valid_out & !out_ready.
// error is meaningful only in the single cycle valid_error is high.
interface uart_rx_param_if #(
  parameter int WIDTH_CONFIG_ADDR = 4,
  parameter int WIDTH_CONFIG_DATA = 8,
  parameter int MAX_DATABITS      = 9,
  parameter int WIDTH_ERROR       = 3
);
  logic [WIDTH_CONFIG_ADDR-1:0] c_addr;
  logic [WIDTH_CONFIG_DATA-1:0] c_data;
  logic                         c_valid;
  logic                         c_ready;
  logic [MAX_DATABITS-1:0]      out;
  logic                         valid_out;
  logic                         out_ready;
  logic [WIDTH_ERROR-1:0]       error;
  logic                         valid_error;

  modport master (
    output c_addr, c_data, c_valid, out_ready,
    input  c_ready, out, valid_out, error, valid_error
  );

  modport slave (
    input  c_addr, c_data, c_valid, out_ready,
    output c_ready, out, valid_out, error, valid_error
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received words; output reads as zero while empty.
module uart_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) cnt_d = cnt_q + (AW+1)'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled start/data/parity/stop decoding, runtime
// frame format and divisor, ready/valid output. UART_RX_FIFO_EN selects a FIFO over a holding register.
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int          WIDTH_CONFIG_ADDR = 4,
  parameter int          WIDTH_CONFIG_DATA = 8,
  parameter int          MAX_DATABITS      = 9,
  parameter int          OVERSAMPLE        = 16,
  parameter logic [15:0] DEFAULT_DIV       = 16'd26,
  parameter int          FIFO_AW           = 3,
  parameter int          WIDTH_ERROR       = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in,
  uart_rx_param_if.slave bus,
  output rx_state_e      dbg_state_o
);
  localparam int NBW = $clog2(MAX_DATABITS + 1);
  localparam int PW  = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0]  PH_EARLY = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0]  PH_MID   = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0]  PH_LATE  = PW'(OVERSAMPLE / 2 + 1);
  localparam logic [PW-1:0]  PH_LAST  = PW'(OVERSAMPLE - 1);
  localparam logic [NBW-1:0] RST_NBITS = NBW'(8);

  rx_state_e state_q, state_d;

  logic [2:0] sync_q;
  logic       in_s, fall;

  parity_e          cfg_par_q, cfg_par_d, frm_par_q, frm_par_d;
  logic             cfg_stop2_q, cfg_stop2_d, frm_stop2_q, frm_stop2_d;
  logic [NBW-1:0]   cfg_nbits_q, cfg_nbits_d, frm_nbits_q, frm_nbits_d;
  logic [15:0]      cfg_div_q, cfg_div_d, frm_div_q, frm_div_d;
  logic [4:0]       nb_req;
  logic             cfg_we;

  logic [15:0]             tick_cnt_q, tick_cnt_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [2:0]              smp_q, smp_d;
  logic [NBW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [MAX_DATABITS-1:0] data_q, data_d;
  logic                    par_err_q, par_err_d;

  logic tick, at_vote, bit_end, vote_live, vote_held, parity_en;
  logic eof, eof_frm_err, eof_par_err, frame_ok;
  logic push, pop, overrun, report;

  logic [WIDTH_ERROR-1:0] err_q, err_d, err_bits;
  logic                   verr_q, verr_d;

  // Line synchroniser; the third stage only feeds falling-edge detection.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) sync_q <= 3'b111;
    else       sync_q <= {sync_q[1:0], in};
  end
  assign in_s = sync_q[1];
  assign fall = sync_q[2] && !sync_q[1];

  assign bus.c_ready = (state_q == ST_IDLE);
  assign dbg_state_o = state_q;
  assign cfg_we      = bus.c_valid && bus.c_ready;

  always_comb begin
    cfg_par_d   = cfg_par_q;
    cfg_stop2_d = cfg_stop2_q;
    cfg_nbits_d = cfg_nbits_q;
    cfg_div_d   = cfg_div_q;
    nb_req      = {1'b0, bus.c_data[6:3]} + 5'd5;
    if (cfg_we) begin
      if (bus.c_addr == WIDTH_CONFIG_ADDR'(ADDR_FRAME)) begin
        cfg_par_d   = parity_e'(bus.c_data[1:0]);
        cfg_stop2_d = bus.c_data[2];
        cfg_nbits_d = (nb_req > 5'(MAX_DATABITS)) ? NBW'(MAX_DATABITS) : NBW'(nb_req);
      end else if (bus.c_addr == WIDTH_CONFIG_ADDR'(ADDR_DIV_LO)) begin
        cfg_div_d[7:0] = bus.c_data[7:0];
      end else if (bus.c_addr == WIDTH_CONFIG_ADDR'(ADDR_DIV_HI)) begin
        cfg_div_d[15:8] = bus.c_data[7:0];
      end
    end
  end

  assign tick      = (tick_cnt_q == frm_div_q);
  assign at_vote   = tick && (phase_q == PH_LATE);
  assign bit_end   = tick && (phase_q == PH_LAST);
  assign vote_live = majority3(smp_q[0], smp_q[1], in_s);
  assign vote_held = majority3(smp_q[0], smp_q[1], smp_q[2]);
  assign parity_en = (frm_par_q == PAR_EVEN) || (frm_par_q == PAR_ODD);

  always_comb begin
    state_d     = state_q;
    frm_par_d   = frm_par_q;
    frm_stop2_d = frm_stop2_q;
    frm_nbits_d = frm_nbits_q;
    frm_div_d   = frm_div_q;
    tick_cnt_d  = tick ? 16'd0 : tick_cnt_q + 16'd1;
    phase_d     = phase_q;
    smp_d       = smp_q;
    bit_cnt_d   = bit_cnt_q;
    data_d      = data_q;
    par_err_d   = par_err_q;
    eof         = 1'b0;
    eof_frm_err = 1'b0;

    if (tick) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
      if (phase_q == PH_EARLY) smp_d[0] = in_s;
      if (phase_q == PH_MID)   smp_d[1] = in_s;
      if (phase_q == PH_LATE)  smp_d[2] = in_s;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          // Bit timing restarts on the edge; the frame format is frozen here.
          state_d     = ST_START;
          tick_cnt_d  = 16'd0;
          phase_d     = '0;
          frm_par_d   = cfg_par_q;
          frm_stop2_d = cfg_stop2_q;
          frm_nbits_d = cfg_nbits_q;
          frm_div_d   = cfg_div_q;
          bit_cnt_d   = '0;
          data_d      = '0;
          par_err_d   = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) state_d = vote_held ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          data_d[bit_cnt_q] = vote_held;
          if (bit_cnt_q == frm_nbits_q - NBW'(1)) state_d = parity_en ? ST_PARITY : ST_STOP1;
          else bit_cnt_d = bit_cnt_q + NBW'(1);
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          par_err_d = vote_held != ((^data_q) ^ (frm_par_q == PAR_ODD));
          state_d   = ST_STOP1;
        end
      end
      ST_STOP1: begin
        if (at_vote) begin
          if (!vote_live) begin
            eof         = 1'b1;
            eof_frm_err = 1'b1;
            state_d     = ST_BREAK_WAIT;
          end else if (!frm_stop2_q) begin
            eof     = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (bit_end) begin
          state_d = ST_STOP2;
        end
      end
      ST_STOP2: begin
        if (at_vote) begin
          eof         = 1'b1;
          eof_frm_err = !vote_live;
          state_d     = vote_live ? ST_IDLE : ST_BREAK_WAIT;
        end
      end
      ST_BREAK_WAIT: begin
        if (in_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= ST_IDLE;
      cfg_par_q   <= PAR_NONE;
      cfg_stop2_q <= 1'b0;
      cfg_nbits_q <= RST_NBITS;
      cfg_div_q   <= DEFAULT_DIV;
      frm_par_q   <= PAR_NONE;
      frm_stop2_q <= 1'b0;
      frm_nbits_q <= RST_NBITS;
      frm_div_q   <= DEFAULT_DIV;
      tick_cnt_q  <= '0;
      phase_q     <= '0;
      smp_q       <= 3'b111;
      bit_cnt_q   <= '0;
      data_q      <= '0;
      par_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_par_q   <= cfg_par_d;
      cfg_stop2_q <= cfg_stop2_d;
      cfg_nbits_q <= cfg_nbits_d;
      cfg_div_q   <= cfg_div_d;
      frm_par_q   <= frm_par_d;
      frm_stop2_q <= frm_stop2_d;
      frm_nbits_q <= frm_nbits_d;
      frm_div_q   <= frm_div_d;
      tick_cnt_q  <= tick_cnt_d;
      phase_q     <= phase_d;
      smp_q       <= smp_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      par_err_q   <= par_err_d;
    end
  end

  assign eof_par_err = eof && par_err_q;
  assign frame_ok    = eof && !eof_par_err && !eof_frm_err;

`ifdef UART_RX_FIFO_EN
  logic                    fifo_full, fifo_empty;
  logic [MAX_DATABITS-1:0] fifo_rdata;

  assign pop     = !fifo_empty && bus.out_ready;
  assign push    = frame_ok && (!fifo_full || pop);
  assign overrun = frame_ok && fifo_full && !pop;

  uart_rx_fifo #(
    .WIDTH (MAX_DATABITS),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst_n),
    .push_i  (push),
    .wdata_i (data_q),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.out       = fifo_rdata;
  assign bus.valid_out = !fifo_empty;
`else
  logic                    hold_valid_q, hold_valid_d;
  logic [MAX_DATABITS-1:0] hold_q, hold_d;

  assign pop     = hold_valid_q && bus.out_ready;
  assign push    = frame_ok && (!hold_valid_q || pop);
  assign overrun = frame_ok && hold_valid_q && !pop;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    if (pop) hold_valid_d = 1'b0;
    if (push) begin
      hold_valid_d = 1'b1;
      hold_d       = data_q;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
    end
  end

  assign bus.out       = hold_q;
  assign bus.valid_out = hold_valid_q;
`endif

  assign report = eof_par_err || eof_frm_err || overrun;

  always_comb begin
    err_bits              = '0;
    err_bits[ERR_PARITY]  = eof_par_err;
    err_bits[ERR_FRAMING] = eof_frm_err;
    err_bits[ERR_OVERRUN] = overrun;
    err_d                 = report ? err_bits : err_q;
    verr_d                = report;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      err_q  <= '0;
      verr_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      verr_q <= verr_d;
    end
  end

  assign bus.error       = err_q;
  assign bus.valid_error = verr_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: a frame-level model predicts delivered words and
// error reports, and a per-cycle compare process checks the DUT outputs against it.
module tb_uart_rx_param;
  import uart_rx_pkg::*;

  localparam int OS      = 16;
  localparam int DEF_DIV = 26;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = 8;
`else
  localparam int CAP = 1;
`endif

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic      in_pin = 1'b1;
  rx_state_e dbg_state;

  uart_rx_param_if #(.WIDTH_CONFIG_ADDR(4), .WIDTH_CONFIG_DATA(8), .MAX_DATABITS(9), .WIDTH_ERROR(3)) bus ();

  uart_rx_param #(
    .WIDTH_CONFIG_ADDR (4),
    .WIDTH_CONFIG_DATA (8),
    .MAX_DATABITS      (9),
    .OVERSAMPLE        (OS),
    .DEFAULT_DIV       (16'd26),
    .FIFO_AW           (3),
    .WIDTH_ERROR       (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in          (in_pin),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         failures = 0;
  logic [8:0] exp_word_q[$];
  logic [2:0] exp_err_q[$];
  int         n_words = 0;
  int         n_errs = 0;
  logic [8:0] last_word = '0;
  logic [2:0] last_err = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got 0x%0h, required nothing", name, act);
  endtask

  logic       prev_stall = 1'b0;
  logic       prev_verr = 1'b0;
  logic [8:0] prev_out = '0;

  initial begin : compare
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        prev_stall = 1'b0;
        prev_verr  = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", 32'(bus.valid_out), 32'd1);
          check("stall_out_stable", 32'(bus.out), 32'(prev_out));
        end
        if (bus.valid_error) begin
          check("valid_error_one_cycle", 32'(prev_verr), 32'd0);
          if (exp_err_q.size() == 0) fail_now("unexpected_error", 32'(bus.error));
          else check("error_bits", 32'(bus.error), 32'(exp_err_q.pop_front()));
          n_errs++;
          last_err = bus.error;
        end
        if (bus.valid_out && bus.out_ready) begin
          if (exp_word_q.size() == 0) fail_now("unexpected_word", 32'(bus.out));
          else check("out_word", 32'(bus.out), 32'(exp_word_q.pop_front()));
          n_words++;
          last_word = bus.out;
        end
        prev_stall = bus.valid_out && !bus.out_ready;
        prev_out   = bus.out;
        prev_verr  = bus.valid_error;
      end
    end
  end

  // ---------------- model ----------------
  function automatic logic model_parity(input logic [8:0] data, input int nbits, input int pmode);
    int ones = 0;
    for (int i = 0; i < nbits; i++) ones += int'(data[i]);
    return (pmode == 2) ? logic'(1 - (ones % 2)) : logic'(ones % 2);
  endfunction

  task automatic model_frame(input logic [8:0] data, input int nbits, input int pmode,
                             input bit bad_par, input int stop_low);
    logic [2:0] err = '0;
    logic [8:0] word = '0;
    for (int i = 0; i < nbits; i++) word[i] = data[i];
    if ((pmode == 1 || pmode == 2) && bad_par) err[0] = 1'b1;
    if (stop_low > 0) err[1] = 1'b1;
    if (err != 3'b000) exp_err_q.push_back(err);
    else if (exp_word_q.size() >= CAP) exp_err_q.push_back(3'b100);
    else exp_word_q.push_back(word);
  endtask

  // ---------------- drivers ----------------
  task automatic drive_line(input logic v, input int cycles);
    in_pin = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic rx_frame(input logic [8:0] data, input int nbits, input int pmode, input bit bad_par,
                          input int nstop, input int stop_low, input int div);
    int  bp = (div + 1) * OS;
    logic p;
    model_frame(data, nbits, pmode, bad_par, stop_low);
    drive_line(1'b0, bp);
    for (int i = 0; i < nbits; i++) drive_line(data[i], bp);
    if (pmode == 1 || pmode == 2) begin
      p = model_parity(data, nbits, pmode) ^ bad_par;
      drive_line(p, bp);
    end
    if (stop_low > 0) drive_line(1'b0, bp * stop_low);
    else drive_line(1'b1, bp * nstop);
    drive_line(1'b1, bp * 2);
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d, output logic acc);
    @(negedge clk);
    bus.c_addr  = a;
    bus.c_data  = d;
    bus.c_valid = 1'b1;
    #1 acc = bus.c_ready;
    @(negedge clk);
    bus.c_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic acc;
  int   w0, e0;

  initial begin : main
    bus.c_addr = '0; bus.c_data = '0; bus.c_valid = 1'b0; bus.out_ready = 1'b1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_c_ready", 32'(bus.c_ready), 32'd1);
    check("rst_valid_out", 32'(bus.valid_out), 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    check("rst_valid_error", 32'(bus.valid_error), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);

    check("model_even_0x35", 32'(model_parity(9'h035, 7, 1)), 32'd0);
    check("model_odd_0x1a3", 32'(model_parity(9'h1A3, 9, 2)), 32'd0);

    // 8N1, divisor 0
    cfg_write(4'b0101, 8'h00, acc);
    check("cfg_accept_idle", 32'(acc), 32'd1);
    cfg_write(4'b0110, 8'h00, acc);
    cfg_write(4'b0100, 8'h18, acc);
    w0 = n_words; e0 = n_errs;
    rx_frame(9'h0A5, 8, 0, 1'b0, 1, 0, 0);
    check("a5_count", 32'(n_words - w0), 32'd1);
    check("a5_word", 32'(last_word), 32'h0A5);
    check("a5_no_error", 32'(n_errs - e0), 32'd0);

    // 7E2: bad parity, then good parity
    cfg_write(4'b0100, 8'h15, acc);
    w0 = n_words; e0 = n_errs;
    rx_frame(9'h035, 7, 1, 1'b1, 2, 0, 0);
    check("par_err_count", 32'(n_errs - e0), 32'd1);
    check("par_err_bits", 32'(last_err), 32'h1);
    check("par_err_no_word", 32'(n_words - w0), 32'd0);
    rx_frame(9'h035, 7, 1, 1'b0, 2, 0, 0);
    check("7e2_word", 32'(last_word), 32'h035);

    // break: stop held low 3 bit times, then a clean frame
    cfg_write(4'b0100, 8'h18, acc);
    w0 = n_words; e0 = n_errs;
    rx_frame(9'h05A, 8, 0, 1'b0, 1, 3, 0);
    rx_frame(9'h03C, 8, 0, 1'b0, 1, 0, 0);
    check("break_err_count", 32'(n_errs - e0), 32'd1);
    check("break_word", 32'(last_word), 32'h03C);

    // glitch in IDLE
    w0 = n_words; e0 = n_errs;
    drive_line(1'b0, 3);
    drive_line(1'b1, 40);
    #1;
    check("glitch_c_ready", 32'(bus.c_ready), 32'd1);
    check("glitch_no_output", 32'((n_words - w0) + (n_errs - e0)), 32'd0);

    // overrun with the consumer stalled
    bus.out_ready = 1'b0;
    w0 = n_words; e0 = n_errs;
    for (int i = 0; i < CAP + 1; i++) rx_frame(9'(8'h10 + i), 8, 0, 1'b0, 1, 0, 0);
    check("ovr_err_bits", 32'(last_err), 32'h4);
    check("ovr_err_count", 32'(n_errs - e0), 32'd1);
    check("ovr_no_word_yet", 32'(n_words - w0), 32'd0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    repeat (CAP + 4) @(negedge clk);
    check("ovr_drained", 32'(n_words - w0), 32'(CAP));
    check("ovr_last_word", 32'(last_word), 32'h10 + 32'(CAP) - 32'd1);

    // 9O1 via clamped width field, then 5 bits with parity mode 11 (none)
    cfg_write(4'b0100, 8'h7A, acc);
    rx_frame(9'h1A3, 9, 2, 1'b0, 1, 0, 0);
    check("9o1_word", 32'(last_word), 32'h1A3);
    cfg_write(4'b0100, 8'h03, acc);
    rx_frame(9'h00B, 5, 3, 1'b0, 1, 0, 0);
    check("5n1_word", 32'(last_word), 32'h00B);

    // config write attempted mid-frame must be ignored
    cfg_write(4'b0100, 8'h18, acc);
    fork
      rx_frame(9'h0C3, 8, 0, 1'b0, 1, 0, 0);
      begin
        repeat (50) @(negedge clk);
        cfg_write(4'b0101, 8'h05, acc);
      end
    join
    check("midframe_cfg_rejected", 32'(acc), 32'd0);
    check("midframe_word", 32'(last_word), 32'h0C3);
    rx_frame(9'h066, 8, 0, 1'b0, 1, 0, 0);
    check("div_unchanged_word", 32'(last_word), 32'h066);

    // reset mid-frame, then receive at the default divisor
    drive_line(1'b0, OS * 3);
    rst_n = 1'b1;
    #1;
    check("midrst_out", 32'(bus.out), 32'd0);
    check("midrst_valid_out", 32'(bus.valid_out), 32'd0);
    check("midrst_error", 32'({bus.error, bus.valid_error}), 32'd0);
    check("midrst_c_ready", 32'(bus.c_ready), 32'd1);
    exp_word_q.delete();
    exp_err_q.delete();
    drive_line(1'b1, 4);
    rst_n = 1'b0;
    drive_line(1'b1, 8);
    w0 = n_words;
    rx_frame(9'h055, 8, 0, 1'b0, 1, 0, DEF_DIV);
    check("default_div_count", 32'(n_words - w0), 32'd1);
    check("default_div_word", 32'(last_word), 32'h055);

    repeat (10) @(negedge clk);
    check("words_all_seen", 32'(exp_word_q.size()), 32'd0);
    check("errors_all_seen", 32'(exp_err_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
